// File: rtl/chunked_adder_pkg.sv
// Shared types and pin-map constants for the chunked add/subtract tile.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // uio_in control bits
  localparam int UIO_START  = 0;
  localparam int UIO_VALID  = 1;
  localparam int UIO_SUB    = 2;
  localparam int UIO_CIN    = 3;
  // uio_out status bits
  localparam int UIO_OVALID = 4;
  localparam int UIO_DONE   = 5;
  localparam int UIO_COUT   = 6;
  localparam int UIO_OVF    = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;
  localparam int         CHUNK_MAX   = 4;

endpackage

// File: rtl/chunked_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple of full-adder cells; also exposes the
// carry into the MSB so the caller can derive signed overflow.
module chunk_adder
  import chunked_adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  if (CHUNK < 1 || CHUNK > CHUNK_MAX) begin : g_bad_chunk
    $error("chunk_adder: CHUNK must be 1..%0d", CHUNK_MAX);
  end

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/tt_um_taghreed_eialsalman_chunked_adder.sv
// Multi-cycle WIDTH-bit add/subtract over CHUNK-bit slices, LSB slice first,
// with a registered carry between beats, behind the Tiny Tapeout pin set.
module tt_um_taghreed_eialsalman_chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (WIDTH < 4 || WIDTH > 64 || (WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("WIDTH must be 4..64 and a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic             sub_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [CHUNK-1:0] sum_q;
  logic [3:0]       slice_q;
  logic             out_valid_q, done_q, cout_q, ovf_q;

  logic             start, beat, last_beat;
  logic [CHUNK-1:0] add_sum;
  logic             add_cout, add_c_msb;
  logic             unused_pins;

  assign start     = ena & uio_in[UIO_START];
  assign beat      = ena & ~uio_in[UIO_START] & uio_in[UIO_VALID] & (state_q == RUN);
  assign last_beat = (idx_q == LAST_IDX);

  // B is inverted for subtraction; the +1 comes from the preloaded carry.
  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a     (ui_in[CHUNK-1:0]),
    .b     (ui_in[4 +: CHUNK] ^ {CHUNK{sub_q}}),
    .cin   (carry_q),
    .sum   (add_sum),
    .cout  (add_cout),
    .c_msb (add_c_msb)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: give every always_comb output a default first; a missed branch
  // otherwise infers a latch.
  always_comb begin
    state_d = state_q;
    if (start)                  state_d = RUN;
    else if (beat && last_beat) state_d = DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      slice_q <= '0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (ena) begin
      if (start) begin
        sub_q   <= uio_in[UIO_SUB];
        carry_q <= uio_in[UIO_CIN] ^ uio_in[UIO_SUB];
        idx_q   <= '0;
        done_q  <= 1'b0;
        cout_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (beat) begin
        sum_q   <= add_sum;
        slice_q <= 4'(idx_q);
        carry_q <= add_cout;
        idx_q   <= idx_q + 1'b1;
        if (last_beat) begin
          cout_q <= add_cout;
          ovf_q  <= add_c_msb ^ add_cout;
          done_q <= 1'b1;
        end
      end
    end
  end

  // out_valid is a one-cycle pulse; it also drops to 0 while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid_q <= 1'b0;
    else        out_valid_q <= beat;
  end

  always_comb begin
    uo_out              = {slice_q, 4'(sum_q)};
    uio_out             = '0;
    uio_out[UIO_OVALID] = out_valid_q;
    uio_out[UIO_DONE]   = done_q;
    uio_out[UIO_COUT]   = cout_q;
    uio_out[UIO_OVF]    = ovf_q;
    uio_oe              = UIO_OE_MASK;
  end

  assign unused_pins = ^{ui_in, uio_in[7:4]};

endmodule

// File: doc/tt_um_taghreed_eialsalman_chunked_adder.md
# tt_um_taghreed_eialsalman_chunked_adder

Parametrised, multi-cycle successor to the single-bit full adder tile. It adds or subtracts two WIDTH-bit operands streamed in CHUNK-bit slices, LSB slice first, over the fixed Tiny Tapeout pin set. A registered carry chains the slices together. The block reports carry-out, signed overflow and a done flag. It sits directly behind the standard TT user-project wrapper pins.

## Interface
- WIDTH, 16: operand width in bits. Must be a multiple of CHUNK, from 4 to 64.
- CHUNK, 4: slice width per beat, 1 to 4. NCHUNK = WIDTH/CHUNK.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  design select. When low, all state freezes.
- ui_in  in  8  [CHUNK-1:0] = A slice, [4+CHUNK-1:4] = B slice. Unused bits are ignored.
- uio_in  in  8  [0] start, [1] in_valid, [2] sub (sampled at start), [3] cin (sampled at start). [7:4] are ignored.
- uo_out  out  8  [CHUNK-1:0] = registered sum slice, [7:4] = slice index (mod 16). Other bits are 0.
- uio_out  out  8  [4] out_valid, [5] done, [6] cout, [7] ovf. [3:0] are 0.
- uio_oe  out  8  constant 8'hF0, including during reset.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset: state = IDLE; carry, index, uo_out and uio_out = 0.
- Start, from any state, with ena=1 and start=1:
  - latch sub;
  - set carry = cin XOR sub;
  - set index = 0;
  - clear done, cout and ovf;
  - go to RUN.
- Start has priority over in_valid in the same cycle. A start during RUN aborts the current operation and restarts it.
- RUN beat (ena=1, in_valid=1, no start):
  - compute {c, s} = A + (B XOR {CHUNK{sub}}) + carry;
  - register s into uo_out[CHUNK-1:0] and index into uo_out[7:4];
  - pulse out_valid for one cycle;
  - set carry = c and index = index+1.
- Final beat (index == NCHUNK-1):
  - also register cout = c;
  - register ovf = carry into MSB XOR c;
  - set done = 1 and go to DONE.
- in_valid=0 in RUN: stall. Carry and index hold, and out_valid = 0.
- in_valid outside RUN: ignored.
- DONE: done, cout, ovf and the last sum slice hold until start or reset.
- Subtraction: A − B uses two's complement. cout=1 means no borrow (A ≥ B unsigned).
- ena=0: no register updates at all, and out_valid is forced to hold 0. Pending inputs are not sampled.

## Timing
- Latency: a sum slice appears one cycle after its accepted beat.
- Throughput: one slice per cycle. A full operation takes NCHUNK beats plus one cycle for the start.
- done, cout and ovf assert in the same cycle as the last out_valid.
- A start may be issued the cycle after done. The back-to-back gap is one cycle.
- Reset mid-operation: outputs return to 0 asynchronously. The next operation requires a new start.
- Index wrap-around: index is internally ceil(log2(NCHUNK)) bits wide. uo_out[7:4] shows its low 4 bits only.

## Structure
- Package chunked_adder_pkg contains:
  - state enum {IDLE, RUN, DONE};
  - uio bit-position constants (START, VALID, SUB, CIN, OVALID, DONE, COUT, OVF);
  - UIO_OE_MASK = 8'hF0;
  - CHUNK_MAX = 4.
- Sub-module chunk_adder is a combinational CHUNK-bit ripple of full-adder cells.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, c_msb (the carry into the MSB).
  - The top level holds the FSM, registers and pin mapping.

## Test plan
All cases run at WIDTH=16, CHUNK=4; slices are listed LSB first.
- Add: 0x1234 + 0x0FCD, cin=0. Slices out are 1, 0, 2, 2, so the sum is 0x2201. Expect cout=0, ovf=0, done=1 after the 4th out_valid.
- Carry chain: 0xFFFF + 0x0001 → 0x0000, cout=1, ovf=0.
- Signed overflow: 0x7FFF + 0x0001 → 0x8000, cout=0, ovf=1.
- Subtract: sub=1, 0x0005 − 0x0007 → 0xFFFE, cout=0 (borrow), ovf=0.
- Stalls: insert in_valid=0 gaps and ena=0 cycles between beats of 0x1234+0x0FCD. The result is still 0x2201, with no extra out_valid pulses and the index held during gaps.
- Abort/reset: start mid-operation after 2 beats, then feed 0x0001+0x0001 → 0x0002. Separately, assert rst_n=0 mid-operation and check that all outputs are 0 and uio_oe=8'hF0.
